io_request_controller: RTL and testbench

- Sequences processor IN/OUT instructions against the board I/O.
- An IN stalls the core until the user sets the switches and presses and releases the Set button (debounced), then returns the zero-extended switch value.
- An OUT writes one of two display output registers in a single cycle with no stall.
- Sits between the control unit/datapath and the board switches, button and displays.

---
 rtl/io_request_controller.sv | 160 ++++++++++++++++
 tb/tb_io_request_controller.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_request_controller.sv
// io_request_controller
// Sequences processor IN/OUT instructions against the board I/O. An IN stalls
// the core until the user sets the switches and presses and releases the
// debounced Set button, then returns the zero-extended switch value. An OUT
// writes one of two display registers in a single cycle without stalling.
module io_request_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        op_in_i,
  input  logic        op_out_i,
  input  logic [31:0] endereco_i,
  input  logic [31:0] dados_saida_i,
  input  logic [12:0] switches_i,
  input  logic        set_i,
  output logic        halt_o,
  output logic [31:0] data_in_o,
  output logic [31:0] output0_o,
  output logic [31:0] output1_o,
  output logic        waiting_o,
  output logic        addr_err_o
);

  localparam logic [1:0] ST_IDLE         = 2'd0;
  localparam logic [1:0] ST_WAIT_PRESS   = 2'd1;
  localparam logic [1:0] ST_WAIT_RELEASE = 2'd2;
  localparam logic [1:0] ST_DONE         = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Set button synchronizer and debouncer
  logic             set_meta_q;
  logic             set_s_q;
  logic             deb_q;
  logic             deb_prev_q;
  logic [CNT_W-1:0] cnt_q;
  logic             deb_rise;
  logic             deb_fall;

  // Control FSM and output registers
  logic [1:0]  state_q,    state_d;
  logic [31:0] data_in_q,  data_in_d;
  logic [31:0] output0_q,  output0_d;
  logic [31:0] output1_q,  output1_d;
  logic        waiting_q,  waiting_d;
  logic        addr_err_q, addr_err_d;

  // Two-flop synchronizer: Set is asynchronous to the clock.
  // NOTE: state is always updated with <= so every flop samples the values
  // from before the edge, regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      set_meta_q <= 1'b0;
      set_s_q    <= 1'b0;
    end else begin
      set_meta_q <= set_i;
      set_s_q    <= set_meta_q;
    end
  end

  // Debounce: accept a new level only after it has been stable long enough.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      deb_prev_q <= deb_q;
      if (set_s_q == deb_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        deb_q <= set_s_q;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign deb_rise = deb_q & ~deb_prev_q;
  assign deb_fall = ~deb_q & deb_prev_q;

  // Next-state logic for the FSM, the IN capture and the OUT writes.
  // NOTE: every signal assigned here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    data_in_d  = data_in_q;
    output0_d  = output0_q;
    output1_d  = output1_q;
    addr_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (op_in_i) begin
          // IN takes priority; a simultaneous OUT is dropped.
          state_d = ST_WAIT_PRESS;
        end else if (op_out_i) begin
          if (endereco_i == 32'd0) begin
            output0_d = dados_saida_i;
          end else if (endereco_i == 32'd1) begin
            output1_d = dados_saida_i;
          end else begin
            addr_err_d = 1'b1;
          end
        end
      end
      ST_WAIT_PRESS: begin
        // Only a fresh debounced rising edge is accepted; a button already
        // held when the IN started produces no edge here.
        if (deb_rise) begin
          data_in_d = {19'b0, switches_i};
          state_d   = ST_WAIT_RELEASE;
        end
      end
      ST_WAIT_RELEASE: begin
        if (deb_fall) begin
          state_d = ST_DONE;
        end
      end
      default: begin
        // DONE: single cycle with Halt low so the core consumes DataIn.
        state_d = ST_IDLE;
      end
    endcase
    waiting_d = (state_d == ST_WAIT_PRESS) || (state_d == ST_WAIT_RELEASE);
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      data_in_q  <= '0;
      output0_q  <= '0;
      output1_q  <= '0;
      waiting_q  <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_in_q  <= data_in_d;
      output0_q  <= output0_d;
      output1_q  <= output1_d;
      waiting_q  <= waiting_d;
      addr_err_q <= addr_err_d;
    end
  end

  // Stall is combinational so the core freezes in the cycle the IN decodes.
  assign halt_o = rst_ni & (((state_q == ST_IDLE) & op_in_i) |
                            (state_q == ST_WAIT_PRESS) |
                            (state_q == ST_WAIT_RELEASE));

  assign data_in_o  = data_in_q;
  assign output0_o  = output0_q;
  assign output1_o  = output1_q;
  assign waiting_o  = waiting_q;
  assign addr_err_o = addr_err_q;

endmodule

// File: tb/tb_io_request_controller.sv
// Testbench for io_request_controller: directed scenarios plus randomized
// traffic, all compared every cycle against a transaction-level model.
module tb_io_request_controller;

  localparam int unsigned DEB = 4;

  logic        clk;
  logic        rst_n;
  logic        op_in;
  logic        op_out;
  logic [31:0] endereco;
  logic [31:0] dados;
  logic [12:0] switches;
  logic        set_btn;
  logic        halt;
  logic [31:0] data_in;
  logic [31:0] out0;
  logic [31:0] out1;
  logic        waiting;
  logic        addr_err;

  int total = 0;
  int bad   = 0;

  io_request_controller #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (16)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .op_in_i      (op_in),
    .op_out_i     (op_out),
    .endereco_i   (endereco),
    .dados_saida_i(dados),
    .switches_i   (switches),
    .set_i        (set_btn),
    .halt_o       (halt),
    .data_in_o    (data_in),
    .output0_o    (out0),
    .output1_o    (out1),
    .waiting_o    (waiting),
    .addr_err_o   (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The request is tracked as a transaction phase; the button is modelled as
  // a two-sample delay line followed by a "stable-for-DEB-samples" filter.
  typedef enum int {PH_IDLE, PH_NEED_PRESS, PH_NEED_RELEASE, PH_HANDOFF} phase_t;
  phase_t      m_phase;
  logic        m_meta, m_s, m_deb, m_deb_prev;
  int          m_run;
  logic [31:0] m_data, m_out0, m_out1;
  logic        m_wait, m_err;

  function automatic logic in_wait(input phase_t p);
    return (p == PH_NEED_PRESS) || (p == PH_NEED_RELEASE);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= PH_IDLE;
      m_meta <= 1'b0; m_s <= 1'b0; m_deb <= 1'b0; m_deb_prev <= 1'b0; m_run <= 0;
      m_data <= '0; m_out0 <= '0; m_out1 <= '0; m_wait <= 1'b0; m_err <= 1'b0;
    end else begin
      phase_t nxt;
      nxt   = m_phase;
      m_err <= (m_phase == PH_IDLE) && !op_in && op_out && (endereco > 32'd1);
      case (m_phase)
        PH_IDLE: begin
          if (op_in) nxt = PH_NEED_PRESS;
          else if (op_out && endereco == 32'd0) m_out0 <= dados;
          else if (op_out && endereco == 32'd1) m_out1 <= dados;
        end
        PH_NEED_PRESS: if (m_deb && !m_deb_prev) begin
          m_data <= 32'(switches);
          nxt = PH_NEED_RELEASE;
        end
        PH_NEED_RELEASE: if (!m_deb && m_deb_prev) nxt = PH_HANDOFF;
        default: nxt = PH_IDLE;
      endcase
      m_phase <= nxt;
      m_wait  <= in_wait(nxt);
      // A level is accepted after DEB consecutive samples that differ.
      m_deb_prev <= m_deb;
      if (m_s == m_deb) m_run <= 0;
      else if (m_run + 1 >= int'(DEB)) begin m_deb <= m_s; m_run <= 0; end
      else m_run <= m_run + 1;
      m_s    <= m_meta;
      m_meta <= set_btn;
    end
  end

  // Compare every cycle, just after the active edge.
  always @(posedge clk) begin
    logic exp_halt;
    #2;
    exp_halt = rst_n && ((m_phase == PH_IDLE && op_in) || in_wait(m_phase));
    check("halt",     32'(halt),     32'(exp_halt));
    check("data_in",  data_in,       m_data);
    check("output0",  out0,          m_out0);
    check("output1",  out1,          m_out1);
    check("waiting",  32'(waiting),  32'(m_wait));
    check("addr_err", 32'(addr_err), 32'(m_err));
  end

  // ---------------- stimulus helpers ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_halt_low(input int budget);
    int n = 0;
    while (halt && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (halt) check("halt_timeout", 32'(halt), 32'd0);
  endtask

  task automatic press_release(input int hold, input int gap);
    set_btn = 1'b1; cycles(hold);
    set_btn = 1'b0; cycles(gap);
  endtask

  initial begin
    int set_hold;
    rst_n = 1'b0; op_in = 1'b1; op_out = 1'b0; endereco = '0; dados = '0;
    switches = '0; set_btn = 1'b0;
    cycles(3);
    #1;
    check("rst_halt_forced_low", 32'(halt), 32'd0);
    check("rst_data_in", data_in, 32'd0);
    op_in = 1'b0;
    rst_n = 1'b1;
    cycles(2);

    // OUT writes and bad address
    op_out = 1'b1; endereco = 32'd1; dados = 32'hDEADBEEF;
    cycles(1);
    op_out = 1'b0;
    #1;
    check("out1_written", out1, 32'hDEADBEEF);
    check("out0_untouched", out0, 32'd0);
    op_out = 1'b1; endereco = 32'd0; dados = 32'h12345678;
    cycles(1);
    endereco = 32'd5; dados = 32'hFFFF0000;
    cycles(1);
    op_out = 1'b0;
    #1;
    check("out0_written", out0, 32'h12345678);
    check("addr_err_pulse", 32'(addr_err), 32'd1);
    cycles(1);
    #1;
    check("addr_err_one_cycle", 32'(addr_err), 32'd0);
    check("out1_kept", out1, 32'hDEADBEEF);

    // Basic IN
    switches = 13'h1A5; op_in = 1'b1;
    #1;
    check("in_halt_same_cycle", 32'(halt), 32'd1);
    cycles(2);
    check("in_waiting", 32'(waiting), 32'd1);
    set_btn = 1'b1; cycles(20);
    check("in_captured_while_held", data_in, 32'h000001A5);
    check("in_still_halted", 32'(halt), 32'd1);
    set_btn = 1'b0;
    wait_halt_low(60);
    check("in_done_data", data_in, 32'h000001A5);
    op_in = 1'b0;
    cycles(3);

    // Short glitch ignored, then a real press
    switches = 13'h0F0; op_in = 1'b1;
    cycles(3);
    press_release(2, 10);
    check("glitch_halt", 32'(halt), 32'd1);
    check("glitch_no_capture", data_in, 32'h000001A5);
    set_btn = 1'b1; cycles(8); set_btn = 1'b0;
    wait_halt_low(60);
    check("after_glitch_data", data_in, 32'h000000F0);
    op_in = 1'b0;
    cycles(3);

    // Button held before the IN, switches moved during release wait
    set_btn = 1'b1; cycles(10);
    switches = 13'h777; op_in = 1'b1;
    cycles(10);
    check("held_no_capture", data_in, 32'h000000F0);
    set_btn = 1'b0; cycles(10);
    check("held_still_halted", 32'(halt), 32'd1);
    set_btn = 1'b1; cycles(10);
    switches = 13'h111; cycles(4);
    set_btn = 1'b0;
    wait_halt_low(60);
    check("held_repress_data", data_in, 32'h00000777);
    op_in = 1'b0;
    cycles(3);

    // IN and OUT together: IN wins
    op_in = 1'b1; op_out = 1'b1; endereco = 32'd0; dados = 32'hCAFEF00D;
    cycles(1);
    op_out = 1'b0;
    #1;
    check("in_wins_out0", out0, 32'h12345678);
    check("in_wins_no_err", 32'(addr_err), 32'd0);
    check("in_wins_halt", 32'(halt), 32'd1);
    switches = 13'h0AA;
    set_btn = 1'b1; cycles(10);
    check("abort_waiting", 32'(waiting), 32'd1);
    // Reset during the release wait aborts the request
    rst_n = 1'b0;
    cycles(2);
    set_btn = 1'b0; op_in = 1'b0;
    #1;
    check("abort_data_in", data_in, 32'd0);
    check("abort_halt", 32'(halt), 32'd0);
    check("abort_out1", out1, 32'd0);
    rst_n = 1'b1;
    cycles(8);

    // Randomized traffic
    set_hold = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (set_hold == 0) begin
        set_btn  = 1'($urandom_range(0, 1));
        set_hold = int'($urandom_range(1, 12));
      end else begin
        set_hold--;
      end
      op_in    = in_wait(m_phase) ? 1'b1 : ($urandom_range(0, 3) == 0);
      op_out   = ($urandom_range(0, 2) == 0);
      endereco = 32'($urandom_range(0, 3));
      dados    = $urandom;
      switches = 13'($urandom);
      if ($urandom_range(0, 599) == 0) begin
        rst_n = 1'b0;
        cycles(2);
        rst_n = 1'b1;
      end
    end
    op_in = 1'b0; op_out = 1'b0;
    cycles(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
